// File: rtl/lab1_imul_accum_pkg.sv
// Shared types and message field positions for the multiply-accumulate sequencer.
package lab1_imul_accum_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StWait = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam int unsigned LAST_BIT = 64;
  localparam int unsigned A_MSB    = 63;
  localparam int unsigned A_LSB    = 32;
  localparam int unsigned B_MSB    = 31;
  localparam int unsigned B_LSB    = 0;

  // Single-character state tag for line traces (I/S/W/D).
  function automatic logic [7:0] state_letter(state_e s);
    unique case (s)
      StIdle:  return "I";
      StSend:  return "S";
      StWait:  return "W";
      StDone:  return "D";
      default: return "?";
    endcase
  endfunction

endpackage

// File: rtl/lab1_imul_int_mul_accum_if.sv
// Generic val/rdy channel; master drives val/msg, slave drives rdy.
interface lab1_imul_int_mul_accum_if #(
  parameter int unsigned Width = 32
) ();
  logic             val;
  logic             rdy;
  logic [Width-1:0] msg;

  modport master (output val, output msg, input rdy);
  modport slave  (input val, input msg, output rdy);
endinterface

// File: rtl/lab1_imul_int_mul_accum_dpath.sv
// Datapath: operand/last registers, 32-bit wrapping accumulator, saturating term counter.
module lab1_imul_int_mul_accum_dpath
  import lab1_imul_accum_pkg::*;
#(
  parameter int unsigned p_cnt_nbits = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_op,
  input  logic [64:0]             in_msg,
  input  logic                    acc_add,
  input  logic                    acc_clr,
  input  logic [31:0]             prod,
  output logic [63:0]             op_msg,
  output logic                    last,
  output logic [31+p_cnt_nbits:0] result
);

  logic [31:0]            a_q, b_q;
  logic                   last_q;
  logic [31:0]            acc_q, acc_d;
  logic [p_cnt_nbits-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      last_q <= 1'b0;
    end else if (load_op) begin
      a_q    <= in_msg[A_MSB:A_LSB];
      b_q    <= in_msg[B_MSB:B_LSB];
      last_q <= in_msg[LAST_BIT];
    end
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (acc_clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (acc_add) begin
      acc_d = acc_q + prod;
      if (cnt_q != {p_cnt_nbits{1'b1}}) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign op_msg = {a_q, b_q};
  assign last   = last_q;
  assign result = {cnt_q, acc_q};

endmodule

// File: rtl/lab1_imul_int_mul_accum.sv
// Multiply-accumulate sequencer: forwards operand pairs to an external multiplier,
// sums the products and emits {count, sum} after the term flagged last.
module lab1_imul_int_mul_accum
  import lab1_imul_accum_pkg::*;
#(
  parameter int unsigned p_cnt_nbits = 8
) (
  input logic                       clk,
  input logic                       reset,
  lab1_imul_int_mul_accum_if.slave  in_req,
  lab1_imul_int_mul_accum_if.master mul_req,
  lab1_imul_int_mul_accum_if.slave  mul_resp,
  lab1_imul_int_mul_accum_if.master out_resp
);

  state_e state_q, state_d;
  logic   in_rdy, mul_val, resp_rdy, out_val;
  logic   load_op, acc_add, acc_clr, last;

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Handshake outputs depend only on state, never on an incoming val.
  always_comb begin
    state_d  = state_q;
    in_rdy   = 1'b0;
    mul_val  = 1'b0;
    resp_rdy = 1'b0;
    out_val  = 1'b0;
    load_op  = 1'b0;
    acc_add  = 1'b0;
    acc_clr  = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_rdy = 1'b1;
        if (in_req.val) begin
          load_op = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        mul_val = 1'b1;
        if (mul_req.rdy) state_d = StWait;
      end
      StWait: begin
        resp_rdy = 1'b1;
        if (mul_resp.val) begin
          acc_add = 1'b1;
          state_d = last ? StDone : StIdle;
        end
      end
      StDone: begin
        out_val = 1'b1;
        if (out_resp.rdy) begin
          acc_clr = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d  = state_e'('x);
        in_rdy   = 1'bx;
        mul_val  = 1'bx;
        resp_rdy = 1'bx;
        out_val  = 1'bx;
        load_op  = 1'bx;
        acc_add  = 1'bx;
        acc_clr  = 1'bx;
      end
    endcase
  end

  // Mask handshakes while reset is held so nothing fires before state is known.
  assign in_req.rdy   = in_rdy & ~reset;
  assign mul_req.val  = mul_val & ~reset;
  assign mul_resp.rdy = resp_rdy & ~reset;
  assign out_resp.val = out_val & ~reset;

  lab1_imul_int_mul_accum_dpath #(
    .p_cnt_nbits (p_cnt_nbits)
  ) u_dpath (
    .clk     (clk),
    .reset   (reset),
    .load_op (load_op),
    .in_msg  (in_req.msg),
    .acc_add (acc_add),
    .acc_clr (acc_clr),
    .prod    (mul_resp.msg),
    .op_msg  (mul_req.msg),
    .last    (last),
    .result  (out_resp.msg)
  );

endmodule

// File: tb/tb_lab1_imul_int_mul_accum.sv
// Bench for the multiply-accumulate sequencer with a behavioural multiplier and sum model.
module tb_lab1_imul_int_mul_accum;

  localparam int unsigned CntBits = 8;
  localparam int unsigned OutW    = 32 + CntBits;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lab1_imul_int_mul_accum_if #(.Width(65))   in_req_if ();
  lab1_imul_int_mul_accum_if #(.Width(64))   mul_req_if ();
  lab1_imul_int_mul_accum_if #(.Width(32))   mul_resp_if ();
  lab1_imul_int_mul_accum_if #(.Width(OutW)) out_resp_if ();

  lab1_imul_int_mul_accum #(
    .p_cnt_nbits (CntBits)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_req   (in_req_if),
    .mul_req  (mul_req_if),
    .mul_resp (mul_resp_if),
    .out_resp (out_resp_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int req_stall_pct = 0;
  int out_stall_pct = 0;
  int dly_min = 1;
  int dly_max = 1;
  logic [63:0] req_log[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural multiplier: one product in flight, programmable accept stalls and latency.
  bit          busy = 0;
  int          dly = 0;
  logic [31:0] prod;
  bit          held_valid = 0;
  logic [63:0] held_msg;

  always @(negedge clk) begin
    if (reset) begin
      busy = 0;
      held_valid = 0;
      mul_req_if.rdy  = 1'b0;
      mul_resp_if.val = 1'b0;
      mul_resp_if.msg = '0;
    end else if (busy) begin
      mul_req_if.rdy = 1'b0;
      if (dly > 0) begin
        dly--;
        mul_resp_if.val = 1'b0;
      end else begin
        mul_resp_if.val = 1'b1;
        mul_resp_if.msg = prod;
      end
      if (mul_resp_if.val && mul_resp_if.rdy) busy = 0;
    end else begin
      mul_resp_if.val = 1'b0;
      mul_req_if.rdy  = ($urandom_range(99) >= req_stall_pct);
      if (mul_req_if.val) begin
        if (held_valid) check("mul_req_stable", mul_req_if.msg, held_msg);
        if (mul_req_if.rdy) begin
          busy = 1;
          prod = mul_req_if.msg[63:32] * mul_req_if.msg[31:0];
          dly  = $urandom_range(dly_max, dly_min);
          req_log.push_back(mul_req_if.msg);
          held_valid = 0;
        end else begin
          held_valid = 1;
          held_msg   = mul_req_if.msg;
        end
      end else begin
        held_valid = 0;
      end
    end
  end

  // Call at a negedge; returns at the negedge right after the transfer edge.
  task automatic send(input logic last, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    in_req_if.val = 1'b1;
    in_req_if.msg = {last, a, b};
    while (!in_req_if.rdy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("in_req_accepted", 64'(in_req_if.rdy), 64'd1);
    @(negedge clk);
    in_req_if.val = 1'b0;
  endtask

  task automatic get_result(output logic [OutW-1:0] msg, output int lat);
    logic [OutW-1:0] first = '0;
    bit seen = 0;
    bit done = 0;
    int n = 0;
    msg = '0;
    lat = -1;
    while (!done && n < 3000) begin
      out_resp_if.rdy = ($urandom_range(99) >= out_stall_pct);
      if (out_resp_if.val) begin
        if (seen) begin
          check("out_msg_stable", 64'(out_resp_if.msg), 64'(first));
        end else begin
          seen  = 1;
          first = out_resp_if.msg;
          lat   = n;
        end
        if (out_resp_if.rdy) begin
          done = 1;
          msg  = out_resp_if.msg;
        end
      end
      @(negedge clk);
      n++;
    end
    out_resp_if.rdy = 1'b0;
    check("out_resp_seen", 64'(done), 64'd1);
  endtask

  function automatic logic [OutW-1:0] pack(input int unsigned cnt, input logic [31:0] sum);
    logic [CntBits-1:0] c;
    c = (cnt > 255) ? CntBits'(255) : CntBits'(cnt);
    return {c, sum};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OutW-1:0] res;
    int lat;
    logic [31:0] ta[8];
    logic [31:0] tb[8];
    logic [31:0] sum;
    int nt;

    reset = 1'b1;
    in_req_if.val = 1'b0;
    in_req_if.msg = '0;
    out_resp_if.rdy = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_rdy",    64'(in_req_if.rdy),    64'd0);
    check("rst_mul_val",   64'(mul_req_if.val),   64'd0);
    check("rst_resp_rdy",  64'(mul_resp_if.rdy),  64'd0);
    check("rst_out_val",   64'(out_resp_if.val),  64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_rdy",  64'(in_req_if.rdy),   64'd1);
    check("post_rst_out_msg", 64'(out_resp_if.msg), 64'd0);
    check("post_rst_out_val", 64'(out_resp_if.val), 64'd0);

    // Single term, one-cycle multiplier wait, all sinks ready.
    dly_min = 1; dly_max = 1; req_stall_pct = 0; out_stall_pct = 0;
    send(1'b1, 32'd3, 32'd4);
    get_result(res, lat);
    check("single_result", 64'(res), 64'(pack(1, 32'd12)));
    // send returns one cycle after the fire; val lands 4 cycles after the fire.
    check("single_latency", 64'(lat), 64'd3);

    // Three-term dot product.
    req_log.delete();
    send(1'b0, 32'd2, 32'd5);
    send(1'b0, 32'd7, 32'd3);
    send(1'b1, 32'd10, 32'd10);
    get_result(res, lat);
    check("dot3_result", 64'(res), 64'(pack(3, 32'd131)));
    check("dot3_nreq", 64'(req_log.size()), 64'd3);
    if (req_log.size() == 3) begin
      check("dot3_req0", req_log[0], {32'd2, 32'd5});
      check("dot3_req1", req_log[1], {32'd7, 32'd3});
      check("dot3_req2", req_log[2], {32'd10, 32'd10});
    end

    // Accumulator wraps modulo 2^32.
    send(1'b0, 32'hFFFF_FFFF, 32'd1);
    send(1'b1, 32'd2, 32'd1);
    get_result(res, lat);
    check("wrap_result", 64'(res), 64'(pack(2, 32'd1)));

    // Random sequences with back-pressure on every port.
    for (int s = 0; s < 20; s++) begin
      req_stall_pct = $urandom_range(60);
      out_stall_pct = $urandom_range(60);
      dly_min = 0;
      dly_max = $urandom_range(4);
      nt  = $urandom_range(6, 1);
      sum = '0;
      for (int i = 0; i < nt; i++) begin
        ta[i] = (s % 2 == 0) ? $urandom() : 32'($urandom_range(1000));
        tb[i] = $urandom();
        sum   = sum + ta[i] * tb[i];
      end
      for (int i = 0; i < nt; i++) send(i == nt - 1, ta[i], tb[i]);
      get_result(res, lat);
      check($sformatf("rand%0d_result", s), 64'(res), 64'(pack(nt, sum)));
    end

    // Counter saturation over 300 terms.
    req_stall_pct = 0; out_stall_pct = 0; dly_min = 0; dly_max = 0;
    for (int i = 0; i < 300; i++) send(i == 299, 32'd1, 32'd1);
    get_result(res, lat);
    check("sat_result", 64'(res), 64'(pack(300, 32'd300)));

    // Reset while waiting on a product discards the partial sum.
    dly_min = 6; dly_max = 6;
    send(1'b0, 32'd1, 32'd2);
    send(1'b0, 32'd3, 32'd4);
    repeat (2) @(negedge clk);
    check("midrst_in_wait", 64'(mul_resp_if.rdy), 64'd1);
    check("midrst_no_out",  64'(out_resp_if.val), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_out_val",  64'(out_resp_if.val), 64'd0);
    check("midrst_resp_rdy", 64'(mul_resp_if.rdy), 64'd0);
    check("midrst_out_msg",  64'(out_resp_if.msg), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_in_rdy", 64'(in_req_if.rdy), 64'd1);
    check("midrst_idle_out", 64'(out_resp_if.val), 64'd0);
    dly_min = 1; dly_max = 1;
    send(1'b1, 32'd6, 32'd7);
    get_result(res, lat);
    check("midrst_result", 64'(res), 64'(pack(1, 32'd42)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lab1_imul_int_mul_accum.md
# lab1_imul_int_mul_accum

Multiply-accumulate sequencer that sits directly upstream and downstream of the iterative integer multiplier. It accepts a stream of operand pairs terminated by a `last` flag and forwards each pair to the multiplier over a val/rdy request port. It consumes each 32-bit product on the multiplier response port and accumulates the products. After the last term it emits the 32-bit sum and the term count on an output val/rdy port, so the parent can compute dot products without software-side accumulation.

## Interface
- `p_cnt_nbits`, default 8: width of the term counter; the count saturates at 2^p_cnt_nbits−1.
- `clk`  in  1  clock; single clock domain, all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `in_req_val`  in  1  operand pair valid.
- `in_req_rdy`  out  1  block can accept an operand pair.
- `in_req_msg`  in  65  {last[64], a[63:32], b[31:0]}.
- `mul_req_val`  out  1  request to multiplier valid.
- `mul_req_rdy`  in  1  multiplier accepts request.
- `mul_req_msg`  out  64  {a[63:32], b[31:0]}.
- `mul_resp_val`  in  1  product valid.
- `mul_resp_rdy`  out  1  block accepts product.
- `mul_resp_msg`  in  32  product, low 32 bits of a*b.
- `out_resp_val`  out  1  result valid.
- `out_resp_rdy`  in  1  consumer accepts result.
- `out_resp_msg`  out  32+p_cnt_nbits  {count, sum[31:0]}.

## Operation
- A transfer on any port occurs in a cycle where val && rdy.
- The FSM has four states: IDLE, SEND, WAIT, DONE.
- IDLE:
  - in_req_rdy=1.
  - On in_req fire, latch a, b and last into operand registers, then go to SEND.
- SEND:
  - mul_req_val=1; mul_req_msg is driven from the operand registers.
  - On mul_req fire, go to WAIT.
- WAIT:
  - mul_resp_rdy=1.
  - On mul_resp fire: acc ← acc + mul_resp_msg (mod 2^32, carry discarded); cnt ← cnt+1, saturating at max.
  - Next state is DONE if last_reg=1, otherwise IDLE.
- DONE:
  - out_resp_val=1; out_resp_msg={cnt, acc}.
  - On out_resp fire: acc ← 0, cnt ← 0, go to IDLE.
- At most one multiplier request is outstanding; the block never issues a new mul_req before the previous product has been consumed.
- All val/rdy outputs are zero in any state other than the one listed above. The state decode is the only source of these outputs, so there are no combinational paths from input val to output rdy.
- mul_resp_val arriving outside WAIT is ignored (mul_resp_rdy=0); the product is not lost, because the multiplier holds it.
- in_req with last=1 as the first term yields count=1 and sum=a*b.
- An unused state encoding drives all outputs to X and next_state to X.

## Timing
- While reset is high: state ← IDLE, acc ← 0, cnt ← 0, and all val/rdy outputs read 0.
  - in_req_rdy=1 from the first cycle after reset falls.
  - out_resp_msg=0 after reset.
- Reset asserted mid-operation, in any state, aborts the sequence. The partial sum is discarded and no out_resp is issued.
- Per term with zero stall: in_req fire in cycle t, mul_req_val in t+1, then WAIT from t+2 until the product arrives (multiplier latency L).
- The next in_req_rdy is asserted one cycle after the mul_resp fire.
- After the last product fires, out_resp_val is asserted the following cycle and holds with a stable msg until out_resp_rdy.
- Back-pressure on any port simply holds the current state; no data is dropped or duplicated.

## Structure
- Shared package `lab1_imul_accum_pkg` holds:
  - the state enum (2 bits);
  - message field constants: LAST_BIT=64, A_MSB=63, A_LSB=32, B_MSB=31, B_LSB=0.
- The natural split is a datapath sub-module `lab1_imul_int_mul_accum_dpath` plus the control FSM in the top module. The datapath contains:
  - operand and last registers with load enable;
  - the 32-bit acc register with clear and add;
  - the saturating cnt register.
- The multiplier is not instantiated inside this block; the parent connects the mul_req/mul_resp ports.
- Line trace: in_req, state letter (I/S/W/D), acc, out_resp.

## Test plan
- Single term: (last=1, a=3, b=4), multiplier latency 1, sinks always ready -> out_resp_msg count=1, sum=12; out_resp_val 4 cycles after the in_req fire.
- Three-term dot product: (2,5), (7,3), (last, 10,10) -> count=3, sum=131. Check exactly three mul_req transfers with msgs {2,5}, {7,3}, {10,10}.
- Wrap-around: (0xFFFFFFFF×1), (last, 2×1) -> sum=0x00000001, count=2.
- Random back-pressure: random stalls on mul_req_rdy, delays on mul_resp_val and stalls on out_resp_rdy; 20 random sequences checked against a golden model. mul_req_msg and out_resp_msg must stay stable while val=1 and rdy=0.
- Saturation: 300 terms of (1,1), p_cnt_nbits=8 -> count=255, sum=300.
- Reset mid-sequence: two terms sent, reset pulsed while in WAIT, then (last, 6,7) -> count=1, sum=42, with no spurious out_resp before it.
